// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Purpose:
//   Accepts 16-bit instruction words from an upstream valid/ready source and
//   steps each one through DECODE, EXECUTE and (optionally) WRITEBACK. The
//   latched opcode drives a downstream 4-to-16 decoder (op_sel), qualified by
//   op_en. EXECUTE waits for exec_done from the execution unit and gives up
//   after TIMEOUT_CYCLES cycles with a one-cycle timeout pulse.
//
// Ports:
//   clk          in   1   sole clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   instr_valid  in   1   instruction word present
//   instr_data   in  16   [15:12] opcode, [11:8] rd, [7:0] imm
//   instr_ready  out  1   sequencer can accept an instruction (IDLE)
//   exec_done    in   1   execution-unit completion pulse
//   op_sel       out  4   latched opcode
//   op_en        out  1   high during EXECUTE
//   rd_sel       out  4   latched destination register
//   imm          out  8   latched immediate
//   wb_en        out  1   one-cycle writeback strobe
//   busy         out  1   high whenever not IDLE
//   timeout      out  1   one-cycle pulse after an EXECUTE timeout
//   trap         out  1   illegal-opcode trap flag
//   trap_clr     in   1   clears the trap
//
// Configuration:
//   ILLEGAL_OP_TRAP_EN  when defined, opcode 4'hF traps in DECODE and the
//                       sequencer waits in TRAP until trap_clr. When not
//                       defined, 4'hF executes like any opcode[3]==1
//                       instruction, trap is tied low and trap_clr is unused.
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        instr_ready,
    input  logic        exec_done,
    output logic [3:0]  op_sel,
    output logic        op_en,
    output logic [3:0]  rd_sel,
    output logic [7:0]  imm,
    output logic        wb_en,
    output logic        busy,
    output logic        timeout,
    output logic        trap,
    input  logic        trap_clr
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_TRAP      = 3'd4
    } state_e;

    // Counter value seen in the final allowed EXECUTE cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        op_en_q, op_en_d;
    logic        wb_en_q, wb_en_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic        trap_q, trap_d;

`ifndef ILLEGAL_OP_TRAP_EN
    logic        unused_trap_clr_s;
    assign unused_trap_clr_s = trap_clr;
`endif

    // Next-state, instruction-register, counter and output-register logic.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Acceptance is qualified by the registered ready so that the
                // cycle right after reset (ready still low) never latches.
                if (instr_valid && ready_q) begin
                    ir_d    = instr_data;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                // EXECUTE is only ever entered from here, so clearing the
                // counter now gives a fresh count on every entry.
                cnt_d = 8'd0;
`ifdef ILLEGAL_OP_TRAP_EN
                if (ir_q[15:12] == 4'hF) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXECUTE;
                end
`else
                state_d = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                // exec_done takes priority over the timeout in the last cycle.
                if (exec_done) begin
                    if (ir_q[15] == 1'b0) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITEBACK: begin
                state_d = S_IDLE;
            end
            S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                if (trap_clr) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TRAP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        ready_d = (state_d == S_IDLE);
        op_en_d = (state_d == S_EXECUTE);
        wb_en_d = (state_d == S_WRITEBACK);
        busy_d  = (state_d != S_IDLE);
`ifdef ILLEGAL_OP_TRAP_EN
        trap_d  = (state_d == S_TRAP);
`else
        trap_d  = 1'b0;
`endif
    end

    // State, instruction register, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= 16'h0000;
            cnt_q     <= 8'd0;
            ready_q   <= 1'b0;
            op_en_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            op_en_q   <= op_en_d;
            wb_en_q   <= wb_en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            trap_q    <= trap_d;
        end
    end

    assign instr_ready = ready_q;
    assign op_sel      = ir_q[15:12];
    assign rd_sel      = ir_q[11:8];
    assign imm         = ir_q[7:0];
    assign op_en       = op_en_q;
    assign wb_en       = wb_en_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
    assign trap        = trap_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench for instr_sequencer (TIMEOUT_CYCLES = 8). A
// transaction-level model tracks the in-flight instruction by its age in
// cycles since acceptance; every cycle the DUT outputs are compared with the
// model. Directed scenarios add literal expectations, followed by a
// randomized run with occasional resets.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int TMO = 8;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = 16'h0000;
    logic        instr_ready;
    logic        exec_done = 1'b0;
    logic [3:0]  op_sel;
    logic        op_en;
    logic [3:0]  rd_sel;
    logic [7:0]  imm;
    logic        wb_en;
    logic        busy;
    logic        timeout;
    logic        trap;
    logic        trap_clr = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    instr_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .exec_done   (exec_done),
        .op_sel      (op_sel),
        .op_en       (op_en),
        .rd_sel      (rd_sel),
        .imm         (imm),
        .wb_en       (wb_en),
        .busy        (busy),
        .timeout     (timeout),
        .trap        (trap),
        .trap_clr    (trap_clr)
    );

    always #5 clk = ~clk;

    // Reference model: m_age counts cycles since acceptance (1 = decode
    // cycle, 2.. = execute cycles), m_wb marks the writeback cycle.
    logic [15:0] m_reg  = 16'h0000;
    bit          m_busy = 1'b0;
    bit          m_wb   = 1'b0;
    bit          m_trap = 1'b0;
    bit          m_tout = 1'b0;
    bit          m_rst  = 1'b1;
    int          m_age  = 0;

    function automatic bit exp_ready();
        return !m_busy && !m_rst;
    endfunction

    function automatic bit exp_op_en();
        return m_busy && !m_wb && !m_trap && (m_age >= 2);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model update at each rising edge from the inputs present in that cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_reg = 16'h0000; m_busy = 0; m_wb = 0; m_trap = 0;
            m_tout = 0; m_rst = 1; m_age = 0;
        end else begin
            bit acc;
            acc = exp_ready() && instr_valid;
            m_rst  = 0;
            m_tout = 0;
            if (acc) begin
                m_reg = instr_data; m_busy = 1; m_age = 1;
            end else if (m_busy) begin
                if (m_wb) begin
                    m_busy = 0; m_wb = 0;
                end else if (m_trap) begin
                    if (trap_clr) begin m_busy = 0; m_trap = 0; end
                end else if (m_age == 1) begin
                    if (TRAP_EN && m_reg[15:12] == 4'hF) m_trap = 1;
                    m_age = 2;
                end else if (exec_done) begin
                    if (m_reg[15] == 1'b0) m_wb = 1;
                    else m_busy = 0;
                end else if (m_age - 1 == TMO) begin
                    m_busy = 0; m_tout = 1;
                end else begin
                    m_age = m_age + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("instr_ready", 16'(instr_ready), 16'(exp_ready()));
            chk("op_en",       16'(op_en),       16'(exp_op_en()));
            chk("wb_en",       16'(wb_en),       16'(m_wb));
            chk("busy",        16'(busy),        16'(m_busy));
            chk("timeout",     16'(timeout),     16'(m_tout));
            chk("trap",        16'(trap),        16'(m_trap));
            chk("op_sel",      16'(op_sel),      16'(m_reg[15:12]));
            chk("rd_sel",      16'(rd_sel),      16'(m_reg[11:8]));
            chk("imm",         16'(imm),         16'(m_reg[7:0]));
        end
    end

    // Drive one cycle of inputs, then return just after the next rising edge.
    task automatic cyc(input bit v, input logic [15:0] d, input bit dn,
                       input bit clr, input bit r);
        instr_valid = v; instr_data = d; exec_done = dn;
        trap_clr = clr; reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'h0000, 0, 0, 0);
    endtask

    initial begin
        int n_open, n_tout, n_wb;

        cyc(0, 16'h0000, 0, 0, 1);
        chk_on = 1'b1;
        cyc(0, 16'h0000, 0, 0, 1);
        chk("rst_ready", 16'(instr_ready), 16'h0000);
        chk("rst_busy",  16'(busy),        16'h0000);
        cyc(0, 16'h0000, 0, 0, 0);
        chk("post_rst_ready", 16'(instr_ready), 16'h0001);

        // 2A5C accepted in cycle 1, exec_done in cycle 4.
        cyc(1, 16'h2A5C, 0, 0, 0);
        chk("d1_op_sel", 16'(op_sel), 16'h0002);
        chk("d1_rd_sel", 16'(rd_sel), 16'h000A);
        chk("d1_imm",    16'(imm),    16'h005C);
        chk("d1_op_en_c2", 16'(op_en), 16'h0000);
        cyc(0, 16'h0000, 0, 0, 0);
        chk("d1_op_en_c3", 16'(op_en), 16'h0001);
        cyc(0, 16'h0000, 0, 0, 0);
        chk("d1_op_en_c4", 16'(op_en), 16'h0001);
        cyc(0, 16'h0000, 1, 0, 0);
        chk("d1_wb_c5",  16'(wb_en), 16'h0001);
        chk("d1_op_en_c5", 16'(op_en), 16'h0000);
        cyc(0, 16'h0000, 0, 0, 0);
        chk("d1_ready_c6", 16'(instr_ready), 16'h0001);

        // 9001 with no exec_done: timeout after 8 execute cycles.
        cyc(1, 16'h9001, 0, 0, 0);
        n_open = 0; n_tout = 0; n_wb = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(0, 16'h0000, 0, 0, 0);
            n_open += int'(op_en); n_tout += int'(timeout); n_wb += int'(wb_en);
        end
        chk("d2_op_en_cycles", 16'(n_open), 16'd8);
        chk("d2_timeout_pulses", 16'(n_tout), 16'd1);
        chk("d2_wb_pulses", 16'(n_wb), 16'd0);

        // Opcode 1, exec_done on the 8th execute cycle: writeback wins.
        cyc(1, 16'h1234, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 16'h0000, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0);
        chk("d3_wb", 16'(wb_en), 16'h0001);
        chk("d3_timeout", 16'(timeout), 16'h0000);
        idle_n(1);

        // Reset during execute of opcode 3, then held valid with changing data.
        cyc(1, 16'h3456, 0, 0, 0);
        cyc(1, 16'h7777, 0, 0, 0);
        chk("d5_hold_op_sel", 16'(op_sel), 16'h0003);
        cyc(1, 16'h8888, 0, 0, 0);
        chk("d5_hold_imm", 16'(imm), 16'h0056);
        cyc(0, 16'h0000, 0, 0, 1);
        chk("d4_op_sel", 16'(op_sel), 16'h0000);
        chk("d4_op_en",  16'(op_en),  16'h0000);
        chk("d4_busy",   16'(busy),   16'h0000);
        chk("d4_ready",  16'(instr_ready), 16'h0000);
        cyc(0, 16'h0000, 0, 0, 0);
        cyc(1, 16'h4321, 0, 0, 0);
        chk("d4_fresh_rd_sel", 16'(rd_sel), 16'h0003);
        idle_n(2);
        cyc(0, 16'h0000, 1, 0, 0);
        chk("d4_fresh_wb", 16'(wb_en), 16'h0001);
        idle_n(1);

        // Opcode F.
        cyc(1, 16'hF123, 0, 0, 0);
        cyc(0, 16'h0000, 0, 0, 0);
`ifdef ILLEGAL_OP_TRAP_EN
        chk("d6_trap",  16'(trap),  16'h0001);
        chk("d6_busy",  16'(busy),  16'h0001);
        chk("d6_op_en", 16'(op_en), 16'h0000);
        cyc(1, 16'h1111, 1, 0, 0);
        chk("d6_trap_hold", 16'(trap), 16'h0001);
        chk("d6_ready", 16'(instr_ready), 16'h0000);
        cyc(0, 16'h0000, 0, 1, 0);
        chk("d6_trap_clr", 16'(trap), 16'h0000);
        chk("d6_ready_after", 16'(instr_ready), 16'h0001);
`else
        chk("d6_op_en", 16'(op_en), 16'h0001);
        chk("d6_trap",  16'(trap),  16'h0000);
        cyc(0, 16'h0000, 1, 1, 0);
        chk("d6_no_wb", 16'(wb_en), 16'h0000);
        chk("d6_ready_after", 16'(instr_ready), 16'h0001);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 2) != 0), 16'($urandom),
                ($urandom_range(0, 9) < 2), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 199) == 0));
        end
        idle_n(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
